max_pool_seq: RTL

- Sequential 2x2, stride-2 max-pooling stage directly downstream of the single-channel/multi-channel convolution layer.
- Consumes the flat convolution output vector (D x H x W, IEEE-754 half precision) and produces the pooled D x H/2 x W/2 vector.
- Computes one pooled element per clock under a start/busy/done handshake, so the next layer can launch on done.

---
 rtl/max_pool_seq_pkg.sv | 37 +++
 rtl/max_pool_seq_max4.sv | 22 ++
 rtl/max_pool_seq.sv | 127 ++++++++++++
 3 files changed

// File: rtl/max_pool_seq_pkg.sv
// Shared constants, FSM encoding and the fp16 ordering used by the pooling stage.
// Latency: n/a (declarations and a pure combinational function only).
// Backpressure: n/a.
package max_pool_seq_pkg;

    localparam int FP16_SIGN    = 15;
    localparam int FP16_MAG_MSB = 14;

    // 2x2 window, stride 2
    localparam int POOL_K = 2;
    localparam int POOL_S = 2;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        RUN  = 2'd1,
        DONE = 2'd2
    } state_t;

    // True when x is strictly greater than y. Sign/magnitude ordering on raw bits:
    // NaN/Inf get no special treatment, and +0/-0 compare equal so the caller's
    // first operand is kept on a tie.
    function automatic logic fp16_gt(input logic [15:0] x, input logic [15:0] y);
        logic gt;
        gt = 1'b0;
        if ((x[FP16_MAG_MSB:0] == '0) && (y[FP16_MAG_MSB:0] == '0)) begin
            gt = 1'b0;
        end else if (x[FP16_SIGN] != y[FP16_SIGN]) begin
            gt = ~x[FP16_SIGN];
        end else if (!x[FP16_SIGN]) begin
            gt = (x[FP16_MAG_MSB:0] > y[FP16_MAG_MSB:0]);
        end else begin
            gt = (x[FP16_MAG_MSB:0] < y[FP16_MAG_MSB:0]);
        end
        return gt;
    endfunction

endpackage

// File: rtl/max_pool_seq_max4.sv
// Four-input fp16 max over one pooling window, as a two-level tree (a/b, c/e, then winners).
// Latency: purely combinational.
// Backpressure: none; output follows inputs.
module max_pool_seq_max4
    import max_pool_seq_pkg::*;
(
    input  logic [15:0] i_a,
    input  logic [15:0] i_b,
    input  logic [15:0] i_c,
    input  logic [15:0] i_e,
    output logic [15:0] o_max
);

    logic [15:0] w_ab;
    logic [15:0] w_ce;

    // The second operand only replaces the first when strictly greater, so ties keep the earlier element.
    assign w_ab  = fp16_gt(i_b, i_a) ? i_b : i_a;
    assign w_ce  = fp16_gt(i_e, i_c) ? i_e : i_c;
    assign o_max = fp16_gt(w_ce, w_ab) ? w_ce : w_ab;

endmodule

// File: rtl/max_pool_seq.sv
// Sequential 2x2/stride-2 fp16 max-pool over a flat D x H x W vector, one pooled element per clock.
// Latency: start sampled at edge t, elements written at edges t+1..t+N, done pulses the cycle after t+N.
// Backpressure: none; start is ignored outside IDLE and inputConv must hold steady until done.
module max_pool_seq
    import max_pool_seq_pkg::*;
#(
    parameter int DATA_WIDTH = 16,
    parameter int D          = 1,
    parameter int H          = 28,
    parameter int W          = 28
) (
    input  logic                                  clk,
    input  logic                                  reset,
    input  logic                                  start,
    input  logic [D*H*W*DATA_WIDTH-1:0]           inputConv,
    output logic [D*(H/2)*(W/2)*DATA_WIDTH-1:0]   outputPool,
    output logic                                  busy,
    output logic                                  done
);

    localparam int N   = D * (H/2) * (W/2);
    localparam int IBW = $clog2(D*H*W*DATA_WIDTH);
    localparam int OBW = $clog2(N*DATA_WIDTH);
    localparam int DCW = (D > 1)     ? $clog2(D)     : 1;
    localparam int ICW = (H/2 > 1)   ? $clog2(H/2)   : 1;
    localparam int JCW = (W/2 > 1)   ? $clog2(W/2)   : 1;
    localparam int KCW = (N > 1)     ? $clog2(N)     : 1;

    state_t                   r_state;
    logic [DCW-1:0]           r_d;
    logic [ICW-1:0]           r_i;
    logic [JCW-1:0]           r_j;
    logic [KCW-1:0]           r_k;
    logic                     r_busy;
    logic                     r_done;
    logic [N*DATA_WIDTH-1:0]  r_pool;

    logic [IBW-1:0]           w_elem_a;
    logic [IBW-1:0]           w_elem_b;
    logic [IBW-1:0]           w_elem_c;
    logic [IBW-1:0]           w_elem_e;
    logic [OBW-1:0]           w_off_k;
    logic [DATA_WIDTH-1:0]    w_max;

    // Flat element indices of the current window; top-left is (d, S*i, S*j), the rest are K-1 away.
    assign w_elem_a = (IBW'(r_d) * IBW'(H) + IBW'(r_i) * IBW'(POOL_S)) * IBW'(W)
                    + IBW'(r_j) * IBW'(POOL_S);
    assign w_elem_b = w_elem_a + IBW'(POOL_K - 1);
    assign w_elem_c = w_elem_a + IBW'(W) * IBW'(POOL_K - 1);
    assign w_elem_e = w_elem_c + IBW'(POOL_K - 1);
    assign w_off_k  = OBW'(r_k) * OBW'(DATA_WIDTH);

    max_pool_seq_max4 u_max4 (
        .i_a   (inputConv[w_elem_a * IBW'(DATA_WIDTH) +: DATA_WIDTH]),
        .i_b   (inputConv[w_elem_b * IBW'(DATA_WIDTH) +: DATA_WIDTH]),
        .i_c   (inputConv[w_elem_c * IBW'(DATA_WIDTH) +: DATA_WIDTH]),
        .i_e   (inputConv[w_elem_e * IBW'(DATA_WIDTH) +: DATA_WIDTH]),
        .o_max (w_max)
    );

    // Control FSM: walk j, then i, then d, writing one pooled element per RUN cycle.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            r_state <= IDLE;
            r_d     <= '0;
            r_i     <= '0;
            r_j     <= '0;
            r_k     <= '0;
            r_busy  <= 1'b0;
            r_done  <= 1'b0;
            r_pool  <= '0;
        end else begin
            case (r_state)
                IDLE: begin
                    r_done <= 1'b0;
                    if (start) begin
                        r_state <= RUN;
                        r_busy  <= 1'b1;
                        r_d     <= '0;
                        r_i     <= '0;
                        r_j     <= '0;
                        r_k     <= '0;
                    end
                end
                RUN: begin
                    r_pool[w_off_k +: DATA_WIDTH] <= w_max;
                    if (r_k == KCW'(N - 1)) begin
                        r_state <= DONE;
                        r_busy  <= 1'b0;
                        r_done  <= 1'b1;
                        r_d     <= '0;
                        r_i     <= '0;
                        r_j     <= '0;
                        r_k     <= '0;
                    end else begin
                        r_k <= r_k + 1'b1;
                        if (r_j == JCW'(W/2 - 1)) begin
                            r_j <= '0;
                            if (r_i == ICW'(H/2 - 1)) begin
                                r_i <= '0;
                                r_d <= r_d + 1'b1;
                            end else begin
                                r_i <= r_i + 1'b1;
                            end
                        end else begin
                            r_j <= r_j + 1'b1;
                        end
                    end
                end
                DONE: begin
                    r_done  <= 1'b0;
                    r_state <= IDLE;
                end
                default: begin
                    r_state <= IDLE;
                    r_busy  <= 1'b0;
                    r_done  <= 1'b0;
                end
            endcase
        end
    end

    assign outputPool = r_pool;
    assign busy       = r_busy;
    assign done       = r_done;

endmodule
